// File: rtl/txbuf_drain_ctrl.sv
// txbuf_drain_ctrl: drains a 1-bit tx storage buffer into UART bytes with a timed wrn strobe.
// Optional partial-byte flush enabled by defining SATCOM_TXCTRL_FLUSH_EN.
module txbuf_drain_ctrl #(
  parameter int WRN_WIDTH = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic        bit_tick,
  input  logic        buf_empty,
  input  logic        buf_data,
  output logic        buf_rd,
  input  logic        tbre,
  output logic [7:0]  tdin,
  output logic        wrn,
  output logic        busy,
  output logic        overrun,
  output logic [10:0] byte_count
);
  typedef enum logic [1:0] {COLLECT, WAIT_TBRE, WRITE, RECOVER} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  tdin_q, tdin_d;
  logic [10:0] bc_q, bc_d;
  logic        ov_q, ov_d;
  logic        rdy_q;
  logic        pop;
`ifdef SATCOM_TXCTRL_FLUSH_EN
  logic [2:0]  ecnt_q, ecnt_d;
  logic        flush;
`endif
  // next-state, datapath and strobe decode; ticks are ignored until one edge after reset release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    sr_d    = sr_q;
    tdin_d  = tdin_q;
    bc_d    = bc_q;
    ov_d    = ov_q;
    pop     = rdy_q && bit_tick && !buf_empty && state_q == COLLECT;
`ifdef SATCOM_TXCTRL_FLUSH_EN
    ecnt_d  = ecnt_q;
    flush   = rdy_q && bit_tick && buf_empty && state_q == COLLECT && cnt_q != 4'd0 && ecnt_q == 3'd7;
`endif
    case (state_q)
      COLLECT: begin
        if (pop) begin
          sr_d  = MSB_FIRST ? {sr_q[6:0], buf_data} : {buf_data, sr_q[7:1]};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) state_d = WAIT_TBRE;
        end
`ifdef SATCOM_TXCTRL_FLUSH_EN
        ecnt_d = (pop || cnt_q == 4'd0) ? 3'd0 : (rdy_q && bit_tick && buf_empty) ? ecnt_q + 3'd1 : ecnt_q;
        if (flush) begin
          sr_d    = MSB_FIRST ? sr_q << (4'd8 - cnt_q) : sr_q >> (4'd8 - cnt_q);
          cnt_d   = 4'd8;
          ecnt_d  = 3'd0;
          state_d = WAIT_TBRE;
        end
`endif
      end
      WAIT_TBRE: begin
        if (tbre) begin
          tdin_d  = sr_q;
          wcnt_d  = 4'd0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (wcnt_q == 4'(WRN_WIDTH - 1)) begin
          bc_d    = bc_q + 11'd1;
          state_d = RECOVER;
        end else wcnt_d = wcnt_q + 4'd1;
      end
      RECOVER: begin
        state_d = COLLECT;
        cnt_d   = 4'd0;
        sr_d    = 8'h00;
      end
      default: state_d = COLLECT;
    endcase
    if (state_q != COLLECT && bit_tick && !buf_empty) ov_d = 1'b1;
  end
  // state and datapath registers
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
      cnt_q   <= 4'd0;
      wcnt_q  <= 4'd0;
      sr_q    <= 8'h00;
      tdin_q  <= 8'h00;
      bc_q    <= 11'd0;
      ov_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      sr_q    <= sr_d;
      tdin_q  <= tdin_d;
      bc_q    <= bc_d;
      ov_q    <= ov_d;
      rdy_q   <= 1'b1;
    end
  end
`ifdef SATCOM_TXCTRL_FLUSH_EN
  // consecutive empty-tick counter for the partial-byte flush
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) ecnt_q <= 3'd0;
    else ecnt_q <= ecnt_d;
  end
`endif
  assign buf_rd     = pop;
  assign wrn        = state_q != WRITE;
  assign busy       = !(state_q == COLLECT && cnt_q == 4'd0);
  assign overrun    = ov_q;
  assign tdin       = tdin_q;
  assign byte_count = bc_q;
endmodule

// File: tb/tb_txbuf_drain_ctrl.sv
// tb_txbuf_drain_ctrl: randomized bench with transaction-level model for txbuf_drain_ctrl (MSB- and LSB-first instances)
module tb_txbuf_drain_ctrl;
  logic clk = 0, rst = 0, bit_tick = 0, buf_empty = 1, buf_data = 0, tbre = 0;
  logic buf_rd, wrn, busy, overrun, buf_rd_b, wrn_b, busy_b, overrun_b;
  logic [7:0] tdin, tdin_b, cap, cap_b, last_a, last_b;
  logic [10:0] byte_count, byte_count_b;
  int n_cmp = 0, n_bad = 0;
  int pops = 0, writes = 0, lowrun = 0, last_w = 0, unstable = 0, bad_rd = 0;
  int bc_m = 0;
  logic ov_m = 0;
  int w0, p0, k;

  always #5 clk = ~clk;

  txbuf_drain_ctrl #(.WRN_WIDTH(4), .MSB_FIRST(1)) dut_a (
    .clk_100M(clk), .rst(rst), .bit_tick(bit_tick), .buf_empty(buf_empty), .buf_data(buf_data),
    .buf_rd(buf_rd), .tbre(tbre), .tdin(tdin), .wrn(wrn), .busy(busy), .overrun(overrun),
    .byte_count(byte_count));

  txbuf_drain_ctrl #(.WRN_WIDTH(4), .MSB_FIRST(0)) dut_b (
    .clk_100M(clk), .rst(rst), .bit_tick(bit_tick), .buf_empty(buf_empty), .buf_data(buf_data),
    .buf_rd(buf_rd_b), .tbre(tbre), .tdin(tdin_b), .wrn(wrn_b), .busy(busy_b), .overrun(overrun_b),
    .byte_count(byte_count_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // observes pops and wrn pulses; captures the byte at the start of each pulse
  always @(negedge clk) begin
    if (!rst) lowrun = 0;
    else begin
      if (buf_rd) pops++;
      if (buf_rd && buf_empty) bad_rd++;
      if (wrn_b !== wrn || buf_rd_b !== buf_rd) bad_rd++;
      if (!wrn) begin
        lowrun++;
        if (lowrun == 1) begin
          cap = tdin;
          cap_b = tdin_b;
        end else if (tdin !== cap || tdin_b !== cap_b) unstable++;
      end else if (lowrun > 0) begin
        if (tdin !== cap || tdin_b !== cap_b) unstable++;
        last_w = lowrun;
        last_a = cap;
        last_b = cap_b;
        writes++;
        lowrun = 0;
      end
    end
  end

  function automatic logic [7:0] msb_of(input logic [7:0] s, input int n);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < n; i++) r[7-i] = s[i];
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic e, input logic d);
    bit_tick = 1;
    buf_empty = e;
    buf_data = d;
    cyc(1);
    bit_tick = 0;
    buf_empty = 1'($urandom);
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (writes < target && n < 2000) begin
      cyc(1);
      n++;
    end
    chk("write_timeout", 32'(writes >= target), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      cyc(1);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic send_byte(input logic [7:0] s, input int tdelay, input logic inj, input logic inj_e);
    int sw0 = writes, sp0 = pops;
    tbre = (tdelay == 0);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) begin
        tick(1, 1'($urandom));
        cyc($urandom_range(0, 2));
      end
      tick(0, s[i]);
      cyc($urandom_range(0, 3));
    end
    if (tdelay > 0) begin
      for (int c = 0; c < tdelay; c++)
        if (inj && c == 3) tick(inj_e, 1);
        else cyc(1);
      chk("wait_nowrite", writes - sw0, 0);
      chk("wait_pops", pops - sp0, 8);
      if (inj && !inj_e) ov_m = 1;
      tbre = 1;
      cyc(2);
      tbre = 1'($urandom);
    end
    wait_wr(sw0 + 1);
    bc_m = (bc_m + 1) % 2048;
    wait_idle();
    chk("pops", pops - sp0, 8);
    chk("byte_msb", last_a, msb_of(s, 8));
    chk("byte_lsb", last_b, s);
    chk("wrn_width", last_w, 4);
    chk("byte_count", byte_count, bc_m);
    chk("overrun", overrun, ov_m);
  endtask

  initial begin
    cyc(3);
    chk("rst_tdin", tdin, 0);
    chk("rst_wrn", wrn, 1);
    chk("rst_buf_rd", buf_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_byte_count", byte_count, 0);
    rst = 1;
    cyc(3);
    send_byte(8'hA5, 0, 0, 0);
    send_byte(8'h03, 0, 0, 0);
    send_byte(8'h5C, 100, 1, 0);
    for (int r = 0; r < 20; r++)
      send_byte(8'($urandom), $urandom_range(0, 1) ? $urandom_range(4, 20) : 0, 1'($urandom), 1'($urandom));
    tbre = 1;
    for (int i = 0; i < 8; i++) tick(0, 1);
    k = 0;
    while (lowrun != 1 && k < 100) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("midwrite_timeout", 32'(lowrun == 1), 1);
    rst = 0;
    #1;
    chk("midrst_wrn", wrn, 1);
    chk("midrst_byte_count", byte_count, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_busy", busy, 0);
    cyc(2);
    rst = 1;
    cyc(3);
    bc_m = 0;
    ov_m = 0;
    w0 = writes;
    buf_data = 1;
    buf_empty = 0;
    bit_tick = 1;
    k = 0;
    while (writes < w0 + 2047 && k < 40000) begin
      @(posedge clk);
      #2;
      k++;
    end
    bit_tick = 0;
    cyc(1);
    chk("wrap_writes", writes - w0, 2047);
    chk("wrap_2047", byte_count, 2047);
    bc_m = 2047;
    ov_m = 1;
    send_byte(8'($urandom), 0, 0, 0);
    w0 = writes;
    p0 = pops;
    tbre = 1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 1);
      cyc(1);
    end
`ifdef SATCOM_TXCTRL_FLUSH_EN
    for (int i = 0; i < 8; i++) begin
      tick(1, 0);
      cyc(1);
    end
    wait_wr(w0 + 1);
    chk("flush_msb", last_a, 8'hE0);
    chk("flush_lsb", last_b, 8'h07);
    chk("flush_pops", pops - p0, 3);
`else
    for (int i = 0; i < 100; i++) begin
      tick(1, 0);
      cyc(1);
    end
    chk("hold_nowrite", writes - w0, 0);
    chk("hold_busy", busy, 1);
    chk("hold_pops", pops - p0, 3);
`endif
    chk("bad_buf_rd", bad_rd, 0);
    chk("tdin_unstable", unstable, 0);
    chk("b_byte_count", byte_count_b, byte_count);
    chk("b_overrun", overrun_b, overrun);
    chk("b_busy", busy_b, busy);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
